// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: FSM encoding,
// blank segment pattern and small constant helpers used for sizing.
package hex_disp_pkg;

  // Scan FSM: dark gap between digits, then the lit dwell of one digit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low segments: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Widest digit bank the scanner supports.
  localparam int MAX_DIGITS = 8;

  // All-ones anode pattern (every digit dark) for a bank of `width` digits.
  // Callers cast the result down to their own bank width.
  function automatic logic [MAX_DIGITS-1:0] an_off(input int width);
    logic [MAX_DIGITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // Width of the shared dwell/blank counter: enough bits for the longer of
  // the two periods, never less than one bit.
  function automatic int cnt_width(input int dwell, input int blank);
    int longest;
    longest = (dwell > blank) ? dwell : blank;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/counter_Hexa.sv
// Combinational hex-to-7-segment decoder, active-low, bit 0 = segment a
// (pattern order gfedcba).
module counter_Hexa
  import hex_disp_pkg::*;
(
  input  logic [3:0] A,
  output logic [6:0] oM
);

  // Map one hex nibble to its segment pattern.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely
    // combinational; a path that leaves oM unassigned would infer a latch.
    oM = SEG_BLANK;
    case (A)
      4'h0: oM = 7'b1000000;
      4'h1: oM = 7'b1111001;
      4'h2: oM = 7'b0100100;
      4'h3: oM = 7'b0110000;
      4'h4: oM = 7'b0011001;
      4'h5: oM = 7'b0010010;
      4'h6: oM = 7'b0000010;
      4'h7: oM = 7'b1111000;
      4'h8: oM = 7'b0000000;
      4'h9: oM = 7'b0011000;
      4'hA: oM = 7'b0001000;
      4'hB: oM = 7'b0000011;
      4'hC: oM = 7'b1000110;
      4'hD: oM = 7'b0100001;
      4'hE: oM = 7'b0000110;
      4'hF: oM = 7'b0001110;
      default: oM = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode 7-segment controller. A two-state FSM
// alternates a dark gap (BLANK) and a lit dwell (SHOW) for each digit in
// turn; one shared decoder converts the selected digit register. Every
// output is registered, so pins follow the FSM with one cycle of lag.
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [AW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int                    CNT_W      = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0]         IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = NUM_DIGITS'(an_off(NUM_DIGITS));

  scan_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_digits [NUM_DIGITS];

  logic [3:0]            w_digit;
  logic [6:0]            w_seg;
  logic                  w_lit;
  logic                  w_dwell_end;
  logic [NUM_DIGITS-1:0] w_an_sel;

  // Digit currently in its slot feeds the single shared decoder.
  assign w_digit     = r_digits[r_idx];
  // The slot drives the pins only while showing and not masked off.
  assign w_lit       = (r_state == SHOW) && !blank_mask[r_idx];
  assign w_dwell_end = (r_state == SHOW) && (r_cnt == DWELL_LAST);
  // One-hot-low anode for the current slot.
  assign w_an_sel    = ~(NUM_DIGITS'(1) << r_idx);

  counter_Hexa u_decoder (
    .A  (w_digit),
    .oM (w_seg)
  );

  // Host write port into the digit register file; out-of-range indices drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this register file is small and must read as 0 after reset,
      // so every entry is cleared explicitly; a large RAM would not be.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digits[i] <= 4'h0;
      end
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      r_digits[wr_addr] <= wr_data;
    end
  end

  // Scan FSM plus registered pin drivers, all computed from pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // right-hand side below sees the value from before this edge.
      r_state    <= BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      case (r_state)
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= SHOW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (w_dwell_end) begin
            r_cnt   <= '0;
            r_state <= BLANK;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= BLANK;
        end
      endcase

      seg        <= w_lit ? w_seg    : SEG_BLANK;
      an         <= w_lit ? w_an_sel : AN_OFF;
      digit_idx  <= r_idx;
      // Pulse right after the last digit's dwell ends and the scan wraps.
      frame_tick <= w_dwell_end && (r_idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with 4 digits, dwell 4, blank 2.
// Edge e counts rising edges after rst is released (edge 1 = first with
// rst low). Each slot spans 6 edges: two dark, then four lit.
module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BK    = 2;
  localparam int SLOT  = DW + BK;
  localparam int FRAME = ND * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] blank_mask;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int         n_checks = 0;
  int         n_errors = 0;
  int         e = 0;
  logic [3:0] m_dig [ND];

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Segment patterns copied from the decode table (gfedcba, active-low).
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int slot_of(input int en);
    return ((en - 1) / SLOT) % ND;
  endfunction

  function automatic bit lit_at(input int en);
    return (en >= 1) && (((en - 1) % SLOT) >= BK) && !blank_mask[slot_of(en)];
  endfunction

  function automatic logic [3:0] exp_an(input int en);
    return lit_at(en) ? ~(4'b0001 << slot_of(en)) : 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg(input int en);
    return lit_at(en) ? hex7(m_dig[slot_of(en)]) : 7'b1111111;
  endfunction

  function automatic logic [2:0] exp_idx_tick(input int en);
    logic [1:0] idx;
    idx = (en >= 1) ? 2'(slot_of(en)) : 2'd0;
    return {idx, (en > 0) && (en % FRAME == 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    e   = 0;
    clear_model();
  endtask

  // Reset values, with a write presented during reset that must be dropped.
  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5; blank_mask = 4'b0000;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (an !== 4'b1111) begin
      n_errors++; $display("FAIL reset_an: got %b want 1111", an);
    end
    n_checks++;
    if (seg !== 7'b1111111) begin
      n_errors++; $display("FAIL reset_seg: got %b want 1111111", seg);
    end
    n_checks++;
    if (digit_idx !== 2'd0) begin
      n_errors++; $display("FAIL reset_digit_idx: got %0d want 0", digit_idx);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
    end
    rst = 1'b0;
    e   = 0;
    clear_model();
  endtask

  // First slots after release: timing of blank gap, dwell and next digit.
  task automatic test_first_scan();
    for (int i = 1; i <= 12; i++) begin
      step();
      n_checks++;
      if ({an, seg} !== {exp_an(e), exp_seg(e)}) begin
        n_errors++;
        $display("FAIL first_scan_pins edge %0d: got an=%b seg=%b want an=%b seg=%b",
                 e, an, seg, exp_an(e), exp_seg(e));
      end
      n_checks++;
      if ({digit_idx, frame_tick} !== exp_idx_tick(e)) begin
        n_errors++;
        $display("FAIL first_scan_idx edge %0d: got idx=%0d tick=%b want %b",
                 e, digit_idx, frame_tick, exp_idx_tick(e));
      end
      if (e == 2 || e == 7) begin
        n_checks++;
        if (an !== 4'b1111) begin
          n_errors++; $display("FAIL first_scan_dark edge %0d: got an=%b want 1111", e, an);
        end
      end
      if (e == 3 || e == 6) begin
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b1000000}) begin
          n_errors++;
          $display("FAIL first_scan_digit0 edge %0d: got an=%b seg=%b want an=1110 seg=1000000", e, an, seg);
        end
      end
      if (e == 9) begin
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b1000000}) begin
          n_errors++;
          $display("FAIL first_scan_digit1 edge %0d: got an=%b seg=%b want an=1101 seg=1000000", e, an, seg);
        end
      end
    end
  endtask

  // Writes to digits 2 and 1, then one full frame showing them.
  task automatic test_writes();
    do_reset();
    for (int i = 1; i <= FRAME; i++) begin
      wr_en   = (i <= 2);
      wr_addr = (i == 1) ? 2'd2 : 2'd1;
      wr_data = (i == 1) ? 4'hA : 4'h3;
      step();
      n_checks++;
      if ({an, seg} !== {exp_an(e), exp_seg(e)}) begin
        n_errors++;
        $display("FAIL writes_pins edge %0d: got an=%b seg=%b want an=%b seg=%b",
                 e, an, seg, exp_an(e), exp_seg(e));
      end
      if (e == 9) begin
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b0110000}) begin
          n_errors++;
          $display("FAIL writes_slot1: got an=%b seg=%b want an=1101 seg=0110000", an, seg);
        end
      end
      if (e == 15) begin
        n_checks++;
        if ({an, seg} !== {4'b1011, 7'b0001000}) begin
          n_errors++;
          $display("FAIL writes_slot2: got an=%b seg=%b want an=1011 seg=0001000", an, seg);
        end
      end
      if (i == 1) m_dig[2] = 4'hA;
      if (i == 2) m_dig[1] = 4'h3;
    end
    wr_en = 1'b0;
  endtask

  // Two more free-running frames: tick period, width and digit_idx order.
  task automatic test_frame_tick();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      n_checks++;
      if ({digit_idx, frame_tick} !== exp_idx_tick(e)) begin
        n_errors++;
        $display("FAIL tick_idx edge %0d: got idx=%0d tick=%b want %b",
                 e, digit_idx, frame_tick, exp_idx_tick(e));
      end
      if (e == 48 || e == 49) begin
        n_checks++;
        if ({digit_idx, frame_tick} !== ((e == 48) ? 3'b11_1 : 3'b00_0)) begin
          n_errors++;
          $display("FAIL tick_wrap edge %0d: got idx=%0d tick=%b", e, digit_idx, frame_tick);
        end
      end
    end
    n_checks++;
    if (ticks != 2) begin
      n_errors++; $display("FAIL tick_count: got %0d want 2", ticks);
    end
  endtask

  // Mask digit 2 for one frame; timing and tick must not move.
  task automatic test_blank_mask();
    blank_mask = 4'b0100;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an(e), exp_seg(e), exp_idx_tick(e)}) begin
        n_errors++;
        $display("FAIL mask_pins edge %0d: got an=%b seg=%b idx=%0d tick=%b want an=%b seg=%b",
                 e, an, seg, digit_idx, frame_tick, exp_an(e), exp_seg(e));
      end
      if (e == 87) begin
        n_checks++;
        if ({an, seg} !== {4'b1111, 7'b1111111}) begin
          n_errors++;
          $display("FAIL mask_slot2: got an=%b seg=%b want an=1111 seg=1111111", an, seg);
        end
      end
    end
    blank_mask = 4'b0000;
  endtask

  // Overwrite the lit digit 0 mid-dwell (write sampled at edge 100).
  task automatic test_live_write();
    for (int i = 0; i < 12; i++) begin
      wr_en   = (e + 1 == 100);
      wr_addr = 2'd0;
      wr_data = 4'hF;
      step();
      n_checks++;
      if ({an, seg} !== {exp_an(e), exp_seg(e)}) begin
        n_errors++;
        $display("FAIL live_pins edge %0d: got an=%b seg=%b want an=%b seg=%b",
                 e, an, seg, exp_an(e), exp_seg(e));
      end
      if (e == 100) begin
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b1000000}) begin
          n_errors++;
          $display("FAIL live_before: got an=%b seg=%b want an=1110 seg=1000000", an, seg);
        end
        m_dig[0] = 4'hF;
      end
      if (e == 101) begin
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b0001110}) begin
          n_errors++;
          $display("FAIL live_after: got an=%b seg=%b want an=1110 seg=0001110", an, seg);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  // One-cycle reset in the middle of digit 2's dwell, then a clean frame.
  task automatic test_reset_mid_show();
    while (e < 112) step();
    n_checks++;
    if (an !== 4'b1011) begin
      n_errors++; $display("FAIL midreset_pre: got an=%b want 1011", an);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({an, seg, digit_idx, frame_tick} !== {4'b1111, 7'b1111111, 2'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL midreset_values: got an=%b seg=%b idx=%0d tick=%b want an=1111 seg=1111111 idx=0 tick=0",
               an, seg, digit_idx, frame_tick);
    end
    e = 0;
    clear_model();
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an(e), exp_seg(e), exp_idx_tick(e)}) begin
        n_errors++;
        $display("FAIL midreset_frame edge %0d: got an=%b seg=%b idx=%0d tick=%b want an=%b seg=%b",
                 e, an, seg, digit_idx, frame_tick, exp_an(e), exp_seg(e));
      end
      if (e == 15) begin
        n_checks++;
        if ({an, seg} !== {4'b1011, 7'b1000000}) begin
          n_errors++;
          $display("FAIL midreset_digit2_cleared: got an=%b seg=%b want an=1011 seg=1000000", an, seg);
        end
      end
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; blank_mask = 4'b0000; rst = 1'b1;
    clear_model();
    test_reset();
    test_first_scan();
    test_writes();
    test_frame_tick();
    test_blank_mask();
    test_live_write();
    test_reset_mid_show();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
